avalon_onchip_ram: RTL
======================

# avalon_onchip_ram

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It is the next-generation replacement for the fixed 2048x32 unregistered-output memory in the Qsys system. It adds:
- configurable width, depth and byte lanes;
- an optional output register stage;
- pipelined reads signalled by `readdatavalid`;
- a write-protect window over the low address range, with a sticky violation flag.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 11: word address width.
- `DEPTH`, 2048: number of words; must be ≤ 2^ADDR_WIDTH.
- `OUTPUT_REG`, 0: 0 gives read latency 1; 1 gives read latency 2.
- `WP_LIMIT`, 0: words [0, WP_LIMIT) are write-protected while `wp_en`=1. 0 disables protection.
- `INIT_FILE`, "avalon_onchip_ram.hex": memory initialisation file. Contents are loaded at configuration only.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `reset_req` in 1: reset-request; while high it behaves as `clken`=0.
- `clken` in 1: clock enable for the whole block.
- `chipselect` in 1: slave select.
- `read` in 1: read request; qualified by `chipselect`.
- `write` in 1: write request; qualified by `chipselect`.
- `address` in ADDR_WIDTH: word address.
- `byteenable` in DATA_WIDTH/8: per-byte write enable.
- `writedata` in DATA_WIDTH: write data.
- `wp_en` in 1: enables the write-protect window.
- `readdata` out DATA_WIDTH: read data, valid only when `readdatavalid`=1.
- `readdatavalid` out 1: one-cycle pulse per accepted read.
- `wr_violation` out 1: sticky flag; set by a write that hits the protected window.

## Operation
- Effective enable: `en` = `clken` & ~`reset_req`. When `en`=0, the following all hold their values: memory, pipeline, `readdata`, `readdatavalid` and `wr_violation`.
- No waitrequest is used. A request is accepted on any edge where `en`=1 and `chipselect`=1.
- Write accept: `write`=1. The block updates the bytes of `mem[address]` whose `byteenable` bit is set; other bytes are unchanged.
- Protected write: `wp_en`=1 and `address` < `WP_LIMIT`.
  - Memory is not modified.
  - `wr_violation` is set to 1 and holds until `reset`.
  - The write is still accepted and completes silently.
- Out-of-range address (≥ `DEPTH`):
  - Writes are dropped.
  - Reads return all-zero data with a normal `readdatavalid`.
- Read accept: `read`=1 and `write`=0.
- Simultaneous `read` and `write`: treated as a write only. No `readdatavalid` is produced.
- Read-during-write across consecutive cycles: a read accepted the cycle after a write to the same address returns the new data.
- Read pipeline:
  - Stage 1 captures `mem[address]` and the valid bit.
  - If `OUTPUT_REG`=1, stage 2 registers stage 1.
  - `readdata` and `readdatavalid` are driven from the last stage.
- Back-to-back reads are accepted every cycle, giving full throughput. The order of `readdatavalid` pulses equals the order in which reads were accepted.
- `reset` has priority over `en`:
  - Clears every valid bit, `readdata`, `readdatavalid` and `wr_violation`.
  - Does not clear memory contents.
  - Any read accepted in the same cycle as `reset`, or still in flight, is dropped and produces no `readdatavalid`.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `wr_violation`=0.
- Read latency: a read accepted at edge N gives `readdatavalid`=1 and valid `readdata` after edge N+1 (`OUTPUT_REG`=0) or after edge N+2 (`OUTPUT_REG`=1). Latency is counted in enabled edges only.
- Writes take effect at the accepting edge. A read accepted at the next edge sees the new value.
- `wr_violation` rises one cycle after the accepting edge of the offending write.
- `readdatavalid` is high for exactly one enabled cycle per accepted read. `readdata` holds its last value when `readdatavalid` is low.
- If `en` falls while a read is in flight, the pulse is delayed, not lost. It appears on the first enabled edge that completes the remaining latency.

## Test plan
- Write 0xDEADBEEF to address 5 with `byteenable`=0xF, then read address 5 → `readdata`=0xDEADBEEF with `readdatavalid` 1 cycle later (`OUTPUT_REG`=0), or 2 cycles later (`OUTPUT_REG`=1).
- Write 0x11223344 to address 7, then write 0xAABBCCDD with `byteenable`=0x5, then read address 7 → `readdata`=0x11BB33DD.
- Issue reads of addresses 0, 1, 2, 3 on four consecutive cycles after preloading each word with its address+0x100 → four consecutive `readdatavalid` pulses carrying 0x100, 0x101, 0x102, 0x103, in order.
- `WP_LIMIT`=16, `wp_en`=1: write 0x0 to address 3, which holds 0x12345678 → address 3 still reads 0x12345678 and `wr_violation`=1. A subsequent `reset` clears `wr_violation` to 0, and address 3 is still 0x12345678.
- Read address 9 (`OUTPUT_REG`=1), then drive `clken`=0 for 3 cycles immediately after acceptance → `readdatavalid` is delayed by 3 cycles and appears exactly once.
- Assert `reset` one cycle after a read is accepted with `OUTPUT_REG`=1 → no `readdatavalid` pulse, and `readdata`=0.

Source files
------------

// File: rtl/avalon_onchip_ram.sv
// ---------------------------------------------------------------------------
// avalon_onchip_ram
//
// Single-port on-chip RAM behind an Avalon-MM slave with pipelined reads.
// Supports byte lanes, an optional output register stage, and a write-protect
// window over the low words with a sticky violation flag.
//
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : word address width
//   DEPTH      : number of words (<= 2**ADDR_WIDTH)
//   OUTPUT_REG : 0 -> read latency 1, 1 -> read latency 2 (enabled edges)
//   WP_LIMIT   : words [0, WP_LIMIT) are protected while wp_en=1 (0 = none)
//   INIT_FILE  : initial-contents image. The device configuration flow binds
//                it to the memory; no load happens in this logic.
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   reset_req        : while high the block behaves as if clken=0
//   clken            : clock enable for the whole block
//   chipselect       : slave select qualifying read/write
//   read, write      : requests (write wins when both are set)
//   address          : word address
//   byteenable       : per-byte write enable
//   writedata        : write data
//   wp_en            : enables the write-protect window
//   readdata         : read data, meaningful while readdatavalid=1
//   readdatavalid    : one enabled-cycle pulse per accepted read
//   wr_violation     : sticky, set by a write into the protected window
// ---------------------------------------------------------------------------
module avalon_onchip_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 11,
    parameter int    DEPTH      = 2048,
    parameter int    OUTPUT_REG = 0,
    parameter int    WP_LIMIT   = 0,
    parameter string INIT_FILE  = "avalon_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    wp_en,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    wr_violation
);

    localparam int BE_W = DATA_WIDTH / 8;

    // Bounds widened by one bit so DEPTH == 2**ADDR_WIDTH still compares cleanly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WP_W    = (ADDR_WIDTH + 1)'(WP_LIMIT);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en;
    logic                  in_range;
    logic                  wp_hit;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign en       = clken & ~reset_req;
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign wp_hit   = wp_en & ({1'b0, address} < WP_W);

    // A cycle carrying reset accepts no request at all.
    assign wr_acc = en & ~reset & chipselect & write;
    assign rd_acc = en & ~reset & chipselect & read & ~write;
    assign mem_we = wr_acc & in_range & ~wp_hit;

    assign rd_word = in_range ? mem[address] : '0;

    // NOTE: the memory array has no reset branch on purpose: contents must
    // survive reset, and a reset on the array would also stop it mapping onto
    // block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 1 and the sticky flag. Data registers load only with a valid read
    // so readdata keeps its last value between pulses.
    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            wr_violation <= 1'b0;
        end else if (en) begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_word;
            end
            if (wr_acc && wp_hit) begin
                wr_violation <= 1'b1;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else if (en) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign readdatavalid = s2_valid;
            assign readdata      = s2_data;
        end else begin : g_no_out_reg
            assign readdatavalid = s1_valid;
            assign readdata      = s1_data;
        end
    endgenerate

endmodule
